// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants, state encoding and flag helper for the FP sequential divider
package fp_pkg;

    localparam logic [31:0] FP_NAN     = 32'h7FC00000;
    localparam logic [7:0]  FP_INF_EXP = 8'hFF;
    localparam int          FP_BIAS    = 127;

    localparam logic [2:0] FLAG_NAN  = 3'b100;
    localparam logic [2:0] FLAG_ZERO = 3'b010;
    localparam logic [2:0] FLAG_INF  = 3'b001;
    localparam logic [2:0] FLAG_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    // Flag encoding shared with the FP ALU, derived purely from the packed result.
    function automatic logic [2:0] flag_of(input logic [31:0] v);
        if (v[30:23] == FP_INF_EXP && v[22:0] != 23'h0) return FLAG_NAN;
        if (v[30:0] == 31'h0)                             return FLAG_ZERO;
        if (v[30:23] == FP_INF_EXP)                       return FLAG_INF;
        return FLAG_NONE;
    endfunction

endpackage

// File: rtl/fp_seq_divider_if.sv
// rtl/fp_seq_divider_if.sv - start/busy/done request interface of the FP sequential divider
interface fp_seq_divider_if;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [2:0]  flag;

    modport master (
        output start, dividend, divisor,
        input  busy, done, result, flag
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, result, flag
    );
endinterface

// File: rtl/fp_div_step.sv
// rtl/fp_div_step.sv - one restoring mantissa division step: compare, subtract, shift
module fp_div_step (
    input  logic [25:0] rem,
    input  logic [23:0] mb,
    output logic [25:0] rem_next,
    output logic        qbit
);
    logic [25:0] diff;

    always_comb begin
        qbit = (rem >= {2'b00, mb});
        diff = qbit ? (rem - {2'b00, mb}) : rem;
        // diff is below mb after a step, so bit 25 is always zero and shifts out safely
        rem_next = {diff[24:0], 1'b0};
    end
endmodule

// File: rtl/fp_seq_divider.sv
// rtl/fp_seq_divider.sv - multi-cycle IEEE-754 single divider with restoring mantissa loop
module fp_seq_divider
    import fp_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    fp_seq_divider_if.slave  bus
);
    localparam int         N_ITER   = 25 / BITS_PER_CYCLE;
    localparam logic [4:0] CNT_LAST = 5'(N_ITER - 1);

    state_t      state;
    logic        sign;
    logic [7:0]  ea, eb;
    logic [23:0] mb;
    logic [25:0] rem;
    logic [24:0] q;
    logic [4:0]  cnt;

    // Operand classification; denormals are flushed to zero.
    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_frac, b_frac;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        sp_nan, sp_inf, sp_zero, is_special;
    logic        op_sign;
    logic [31:0] special_result;

    assign a_exp   = bus.dividend[30:23];
    assign b_exp   = bus.divisor[30:23];
    assign a_frac  = bus.dividend[22:0];
    assign b_frac  = bus.divisor[22:0];
    assign op_sign = bus.dividend[31] ^ bus.divisor[31];

    assign a_nan  = (a_exp == FP_INF_EXP) && (a_frac != 23'h0);
    assign b_nan  = (b_exp == FP_INF_EXP) && (b_frac != 23'h0);
    assign a_inf  = (a_exp == FP_INF_EXP) && (a_frac == 23'h0);
    assign b_inf  = (b_exp == FP_INF_EXP) && (b_frac == 23'h0);
    assign a_zero = (a_exp == 8'h00);
    assign b_zero = (b_exp == 8'h00);

    // Priority: NaN beats infinity beats zero.
    assign sp_nan     = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
    assign sp_inf     = a_inf | b_zero;
    assign sp_zero    = a_zero | b_inf;
    assign is_special = sp_nan | sp_inf | sp_zero;

    always_comb begin
        if (sp_nan)      special_result = FP_NAN;
        else if (sp_inf) special_result = {op_sign, FP_INF_EXP, 23'h0};
        else             special_result = 32'h0;
    end

    // Chain of restoring steps; the first step yields the most significant quotient bit.
    logic [25:0]               rem_chain [0:BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] q_bits;
    logic [24:0]               q_ext;
    logic [24:0]               q_next;

    assign rem_chain[0] = rem;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        fp_div_step u_step (
            .rem      (rem_chain[i]),
            .mb       (mb),
            .rem_next (rem_chain[i+1]),
            .qbit     (q_bits[BITS_PER_CYCLE-1-i])
        );
    end

    always_comb begin
        q_ext = '0;
        q_ext[BITS_PER_CYCLE-1:0] = q_bits;
        q_next = (q << BITS_PER_CYCLE) | q_ext;
    end

    // Normalise and pack: quotient lies in (0.5, 2), so at most one left shift is needed.
    logic signed [9:0] exp_raw, exp_adj;
    logic [22:0]       mant;
    logic [31:0]       norm_result;

    always_comb begin
        exp_raw = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(10'(FP_BIAS));
        if (q[24]) begin
            mant    = q[23:1];
            exp_adj = exp_raw;
        end else begin
            mant    = q[22:0];
            exp_adj = exp_raw - 10'sd1;
        end
        if (exp_adj >= 10'sd255)     norm_result = {sign, FP_INF_EXP, 23'h0};
        else if (exp_adj <= 10'sd0)  norm_result = 32'h0;
        else                         norm_result = {sign, exp_adj[7:0], mant};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= 32'h0;
            bus.flag   <= FLAG_NONE;
            sign       <= 1'b0;
            ea         <= 8'h0;
            eb         <= 8'h0;
            mb         <= 24'h0;
            rem        <= 26'h0;
            q          <= 25'h0;
            cnt        <= 5'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        sign     <= op_sign;
                        ea       <= a_exp;
                        eb       <= b_exp;
                        mb       <= {1'b1, b_frac};
                        rem      <= {3'b001, a_frac};
                        q        <= 25'h0;
                        cnt      <= CNT_LAST;
                        if (is_special) begin
                            bus.result <= special_result;
                            bus.flag   <= flag_of(special_result);
                            bus.done   <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem <= rem_chain[BITS_PER_CYCLE];
                    q   <= q_next;
                    if (cnt == 5'd0) state <= NORM;
                    else             cnt   <= cnt - 5'd1;
                end
                NORM: begin
                    bus.result <= norm_result;
                    bus.flag   <= flag_of(norm_result);
                    bus.done   <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
